sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port between the Nios II data master (port 0) and a DMA/video requester (port 1). It round-robins command grants, holds each granted command stable while the controller stalls, and returns pipelined read data to the master that issued it. A tag FIFO records read ownership, and the block sits between the system interconnect and the SDRAM controller inside the SoC.

## Interface
- ADDR_W, 25: word address width (32M x 32-bit SDRAM)
- DATA_W, 32: data width; byteenable width is DATA_W/8
- MAX_PEND, 8: maximum outstanding reads (tag FIFO depth, power of 2)

- clk_clk  in  1  system clock (same clock as the SDRAM controller)
- reset_reset  in  1  synchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  master word address
- m0_read, m0_write / m1_read, m1_write  in  1  command strobes; never both high on one master
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  command not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid
- s_address  out  ADDR_W; s_read, s_write  out  1; s_writedata  out  DATA_W; s_byteenable  out  DATA_W/8  controller command
- s_waitrequest  in  1  controller stall
- s_readdata  in  DATA_W; s_readdatavalid  in  1  controller response, in issue order
- err_spurious  out  1  sticky flag: a response arrived with no recorded owner

## Operation
- Registers: grant_valid, grant_id (0/1), last_id (round-robin pointer), a tag FIFO of MAX_PEND x 1 bit, a pending count of 0..MAX_PEND, and err_spurious.
- Arbitration happens only when grant_valid=0. Requesting masters are those with read or write high. If one master requests, it is granted. If both request, the master != last_id is granted. The chosen master's command is driven to s_* in the same cycle, and grant_valid is set.
- Hold: while grant_valid=1, s_* follows master grant_id only. Grant does not change while s_waitrequest=1.
- Accept: a command is accepted in the cycle s_(read|write)=1 and s_waitrequest=0. In that cycle:
  - mX_waitrequest=0 for the granted master;
  - grant_valid clears;
  - last_id is set to grant_id.
  
  Every other master sees waitrequest=1 in every cycle.
- Read gating: if count==MAX_PEND, a granted read is not forwarded (s_read=0) and the master sees waitrequest=1. Writes are unaffected.
- An accepted read pushes grant_id into the tag FIFO and increments count.
- Response routing: when s_readdatavalid=1 and count>0, the FIFO is popped and the response goes to the master named by the head tag. That master's readdatavalid is 1 and its readdata is s_readdata. The other master's readdatavalid stays 0.
- If a push and a pop occur in the same cycle, count is unchanged. A pop of the entry pushed that same cycle is impossible, because the controller has latency >= 1.
- Spurious response: s_readdatavalid=1 with count==0 is dropped, and err_spurious is set. Only reset clears it.
- Both mX_readdata outputs always carry s_readdata. Only the valid strobes are steered.

## Timing
- Reset (reset_reset=1 at a clock edge):
  - grant_valid=0, last_id=1 (so master 0 wins the first tie);
  - count=0, FIFO pointers=0, err_spurious=0.
  
  During and after reset until a grant: s_read=s_write=0, mX_waitrequest=1, mX_readdatavalid=0.
- Reset mid-operation discards all pending tags. The controller shares reset, so no pre-reset responses follow.
- Arbitration-to-command latency is 0 cycles: the command appears on s_* in the cycle it is granted. The minimum accept is 1 cycle when s_waitrequest=0.
- Read data path latency is 0 cycles (combinational steering), on top of the controller latency.
- Back-to-back: with both masters requesting continuously and no stalls, grants alternate 0,1,0,1 with one accept per cycle.
- Outputs to masters are combinational from the registered grant/tag state plus s_waitrequest and s_readdatavalid. No path runs combinationally from mX inputs to mX_waitrequest except through the grant selection.

## Test plan
- Single master read: m0 reads address 0x0000010, controller latency 3 with no stall. Expect s_read for 1 cycle, m0_waitrequest=0 in that cycle, then m0_readdatavalid=1 three cycles later with data 0xDEADBEEF. m1_readdatavalid stays 0.
- Tie and round-robin: both masters write continuously after reset. Accepts go m0,m1,m0,m1, and s_writedata alternates between their values.
- Stall hold: controller asserts s_waitrequest for 5 cycles while m1 is granted and m0 starts requesting. s_address stays at m1's value for all 5 cycles, and m0 is granted only after m1's accept.
- Interleaved reads with controller latency 4: issue m0,m1,m0,m1 reads. The four responses return to m0,m1,m0,m1 in order, and count returns to 0.
- FIFO full: issue 8 reads with responses held off. The 9th read sees waitrequest=1 and s_read=0, while a write from the other master is still accepted. After one response, the 9th read is accepted.
- Spurious response and reset: pulse s_readdatavalid with count=0. err_spurious goes to 1 and no master valid is asserted. Assert reset_reset for 1 cycle with 3 reads pending: count=0, err_spurious=0 and mX_waitrequest=1 afterwards.

Source files
------------

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares one SDRAM controller Avalon-MM slave port between two masters
// (port 0: Nios II data master, port 1: DMA/video requester). Command grants
// are round-robin and held stable while the controller stalls. Read data is
// steered back to the issuing master using a small FIFO of 1-bit owner tags.
//
// Ports
//   clk_clk, reset_reset        system clock, synchronous active-high reset
//   m0_* / m1_*                 Avalon-MM slave-side ports facing each master
//   s_*                         Avalon-MM master-side port facing the controller
//   err_spurious                sticky: a read response arrived with no owner
// -----------------------------------------------------------------------------
module sdram_arbiter #(
   parameter int ADDR_W   = 25,
   parameter int DATA_W   = 32,
   parameter int MAX_PEND = 8
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,

   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W-1:0]     s_writedata,
   output logic [DATA_W/8-1:0]   s_byteenable,
   input  logic                  s_waitrequest,
   input  logic [DATA_W-1:0]     s_readdata,
   input  logic                  s_readdatavalid,

   output logic                  err_spurious
);

   localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
   localparam int CNT_W = $clog2(MAX_PEND + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

   // Grant and round-robin state
   logic             grant_valid;
   logic             grant_id;
   logic             last_id;

   // Read-ownership tag FIFO
   logic             tag_fifo [MAX_PEND];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             full;
   logic             req0;
   logic             req1;
   logic             sel_id;
   logic             sel_valid;
   logic             sel_read;
   logic             sel_write;
   logic             accept;
   logic             push;
   logic             pop;
   logic             head_tag;

   assign full = (count == FULL_CNT);

   // A read that cannot be tracked is not a candidate at all, so a gated read
   // never blocks the other master's traffic.
   assign req0 = m0_write | (m0_read & ~full);
   assign req1 = m1_write | (m1_read & ~full);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      sel_id    = 1'b0;
      sel_valid = 1'b0;
      if (reset_reset) begin
         sel_valid = 1'b0;
      end else if (grant_valid) begin
         sel_id    = grant_id;
         sel_valid = 1'b1;
      end else if (req0 && req1) begin
         sel_id    = ~last_id;
         sel_valid = 1'b1;
      end else if (req0) begin
         sel_id    = 1'b0;
         sel_valid = 1'b1;
      end else if (req1) begin
         sel_id    = 1'b1;
         sel_valid = 1'b1;
      end
   end

   assign sel_read  = sel_id ? m1_read  : m0_read;
   assign sel_write = sel_id ? m1_write : m0_write;

   assign s_read       = sel_valid & sel_read & ~full;
   assign s_write      = sel_valid & sel_write;
   assign s_address    = sel_id ? m1_address    : m0_address;
   assign s_writedata  = sel_id ? m1_writedata  : m0_writedata;
   assign s_byteenable = sel_id ? m1_byteenable : m0_byteenable;

   assign accept = (s_read | s_write) & ~s_waitrequest;

   assign m0_waitrequest = ~(accept & ~sel_id);
   assign m1_waitrequest = ~(accept &  sel_id);

   // Response steering: the head tag names the owner of the oldest read.
   assign push     = accept & s_read;
   assign pop      = s_readdatavalid & (count != '0) & ~reset_reset;
   assign head_tag = tag_fifo[rd_ptr];

   assign m0_readdatavalid = pop & ~head_tag;
   assign m1_readdatavalid = pop &  head_tag;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;

   always_ff @(posedge clk_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset_reset) begin
         grant_valid  <= 1'b0;
         grant_id     <= 1'b0;
         last_id      <= 1'b1;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         err_spurious <= 1'b0;
      end else begin
         // A forwarded but stalled command locks the grant until accepted.
         if (accept) begin
            grant_valid <= 1'b0;
            last_id     <= sel_id;
         end else if (s_read || s_write) begin
            grant_valid <= 1'b1;
            grant_id    <= sel_id;
         end

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (s_readdatavalid && (count == '0)) err_spurious <= 1'b1;
      end
   end

   // NOTE: tag storage has no reset; an entry is only read after it has been written.
   always_ff @(posedge clk_clk) begin
      if (push) tag_fifo[wr_ptr] <= sel_id;
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Randomized bench for sdram_arbiter. Two behavioural masters hold each command
// until accepted; a behavioural controller stalls at random and returns reads
// in order after a random latency. A transaction-level reference model (owner
// queue, held master, last winner) predicts every DUT output each cycle, and
// per-master queues of expected read data check that data reaches its issuer.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

   localparam int ADDR_W   = 25;
   localparam int DATA_W   = 32;
   localparam int MAX_PEND = 8;

   logic                clk_clk = 1'b0;
   logic                reset_reset;
   logic [ADDR_W-1:0]   m0_address, m1_address;
   logic                m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0]   m0_writedata, m1_writedata;
   logic [DATA_W/8-1:0] m0_byteenable, m1_byteenable;
   logic                m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0]   m0_readdata, m1_readdata;
   logic                m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0]   s_address;
   logic                s_read, s_write;
   logic [DATA_W-1:0]   s_writedata;
   logic [DATA_W/8-1:0] s_byteenable;
   logic                s_waitrequest;
   logic [DATA_W-1:0]   s_readdata;
   logic                s_readdatavalid;
   logic                err_spurious;

   sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
      .clk_clk          (clk_clk),
      .reset_reset      (reset_reset),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid),
      .err_spurious     (err_spurious)
   );

   always #5 clk_clk = ~clk_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Behavioural masters: one outstanding command each, held until accepted.
   bit                  act [2];
   bit                  rd  [2];
   logic [ADDR_W-1:0]   adr [2];
   logic [DATA_W-1:0]   wdat[2];
   logic [DATA_W/8-1:0] ben [2];

   // Behavioural controller: in-order responses with a due cycle.
   typedef struct {
      int                t;
      logic [DATA_W-1:0] d;
   } resp_t;
   resp_t             cq[$];
   int                last_t = 0;

   // Expected read data per master, oldest first.
   logic [DATA_W-1:0] xq0[$];
   logic [DATA_W-1:0] xq1[$];

   // Reference model state.
   int tags[$];
   int held  = -1;
   int last  = 1;
   bit err_m = 1'b0;

   // Stimulus knobs.
   int   req_pct   = 0;
   int   rd_pct[2] = '{50, 50};
   int   stall_pct = 0;
   int   lat_lo    = 1;
   int   lat_hi    = 4;
   bit   gen_en    = 1'b0;
   bit   hold_resp = 1'b0;
   bit   spur_now  = 1'b0;
   bit   rst       = 1'b1;
   bit   force_en  = 1'b0;
   logic [DATA_W-1:0] force_d = '0;

   task automatic step();
      bit   from_cq;
      bit   el[2];
      int   sz, ch, t;
      bit   e_rd, e_wr, acc, spur;
      bit [1:0] e_v;
      logic [DATA_W-1:0] d, xd;

      // Drive inputs for this cycle.
      reset_reset   = rst;
      m0_read       = act[0] &  rd[0];
      m0_write      = act[0] & ~rd[0];
      m0_address    = adr[0];
      m0_writedata  = wdat[0];
      m0_byteenable = ben[0];
      m1_read       = act[1] &  rd[1];
      m1_write      = act[1] & ~rd[1];
      m1_address    = adr[1];
      m1_writedata  = wdat[1];
      m1_byteenable = ben[1];
      s_waitrequest = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      from_cq = 1'b0;
      if (!hold_resp && cq.size() > 0 && cq[0].t <= cyc) begin
         s_readdatavalid = 1'b1;
         s_readdata      = cq[0].d;
         from_cq         = 1'b1;
      end else if (spur_now) begin
         s_readdatavalid = 1'b1;
         s_readdata      = $urandom;
      end else begin
         s_readdatavalid = 1'b0;
         s_readdata      = $urandom;
      end
      #3;

      // Predict: who owns the slave port this cycle.
      sz = tags.size();
      for (int i = 0; i < 2; i++) el[i] = act[i] && (!rd[i] || sz < MAX_PEND);
      if (rst)                ch = -1;
      else if (held >= 0)     ch = held;
      else if (el[0] && el[1]) ch = 1 - last;
      else if (el[0])         ch = 0;
      else if (el[1])         ch = 1;
      else                    ch = -1;
      e_rd = (ch >= 0) && rd[ch] && (sz < MAX_PEND);
      e_wr = (ch >= 0) && !rd[ch];
      acc  = (e_rd || e_wr) && !s_waitrequest;

      check("s_read", s_read, e_rd);
      check("s_write", s_write, e_wr);
      check("m0_waitrequest", m0_waitrequest, !(acc && ch == 0));
      check("m1_waitrequest", m1_waitrequest, !(acc && ch == 1));
      if (e_rd || e_wr) check("s_address", s_address, adr[ch]);
      if (e_wr) begin
         check("s_writedata", s_writedata, wdat[ch]);
         check("s_byteenable", s_byteenable, ben[ch]);
      end

      // Predict: response routing.
      e_v  = 2'b00;
      spur = 1'b0;
      if (!rst && s_readdatavalid) begin
         if (sz > 0) e_v[tags.pop_front()] = 1'b1;
         else        spur = 1'b1;
      end
      check("m0_readdatavalid", m0_readdatavalid, e_v[0]);
      check("m1_readdatavalid", m1_readdatavalid, e_v[1]);
      if (e_v[0]) begin
         xd = (xq0.size() > 0) ? xq0.pop_front() : 'x;
         check("m0_readdata", m0_readdata, xd);
      end
      if (e_v[1]) begin
         xd = (xq1.size() > 0) ? xq1.pop_front() : 'x;
         check("m1_readdata", m1_readdata, xd);
      end
      if (!rst) check("err_spurious", err_spurious, err_m);

      // Advance the model, controller and masters.
      if (rst) begin
         held = -1; last = 1; err_m = 1'b0; last_t = 0;
         tags.delete(); cq.delete(); xq0.delete(); xq1.delete();
      end else begin
         if (from_cq) void'(cq.pop_front());
         if (spur) err_m = 1'b1;
         if (acc) begin
            held = -1;
            last = ch;
            if (e_rd) begin
               d = force_en ? force_d : DATA_W'($urandom);
               force_en = 1'b0;
               t = cyc + int'($urandom_range(lat_hi, lat_lo));
               if (t <= last_t) t = last_t + 1;
               last_t = t;
               cq.push_back('{t, d});
               if (ch == 0) xq0.push_back(d);
               else         xq1.push_back(d);
               tags.push_back(ch);
            end
            act[ch] = 1'b0;
         end else if (e_rd || e_wr) begin
            held = ch;
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (!act[i] && gen_en && $urandom_range(99) < req_pct) begin
            act[i]  = 1'b1;
            rd[i]   = ($urandom_range(99) < rd_pct[i]);
            adr[i]  = ADDR_W'($urandom);
            wdat[i] = $urandom;
            ben[i]  = (DATA_W/8)'($urandom);
         end
      end
      @(posedge clk_clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Let all traffic finish; a stuck design counts as one failed comparison.
   task automatic drain();
      int  k;
      bit  busy;
      gen_en = 1'b0;
      k = 0;
      busy = 1'b1;
      while (busy && k < 300) begin
         step();
         k++;
         busy = act[0] || act[1] || (tags.size() > 0) || (cq.size() > 0);
      end
      check("drain_done", busy, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; rd[i] = 1'b0; adr[i] = '0; wdat[i] = '0; ben[i] = '0;
      end
      reset_reset = 1'b1;
      @(posedge clk_clk);
      #1;

      // Reset with both masters already requesting: nothing may be forwarded.
      rst = 1'b1;
      act[0] = 1'b1; rd[0] = 1'b0; adr[0] = 25'h0000100; wdat[0] = 32'h1111_0000; ben[0] = 4'hF;
      act[1] = 1'b1; rd[1] = 1'b1; adr[1] = 25'h0000200;
      run(2);
      act[0] = 1'b0; act[1] = 1'b0;
      rst = 1'b0;
      run(2);

      // Single master read, latency 3, known data.
      lat_lo = 3; lat_hi = 3; stall_pct = 0;
      act[0] = 1'b1; rd[0] = 1'b1; adr[0] = 25'h0000010;
      force_en = 1'b1; force_d = 32'hDEAD_BEEF;
      run(6);

      // Both masters writing continuously from reset: strict alternation.
      rst = 1'b1; run(1); rst = 1'b0;
      gen_en = 1'b1; req_pct = 100; rd_pct = '{0, 0};
      run(20);
      drain();

      // Stalls, mixed traffic, varying latency.
      gen_en = 1'b1; req_pct = 60; rd_pct = '{50, 50};
      stall_pct = 40; lat_lo = 1; lat_hi = 5;
      run(400);

      // Interleaved reads at fixed latency 4.
      stall_pct = 0; lat_lo = 4; lat_hi = 4; req_pct = 100; rd_pct = '{100, 100};
      run(40);
      drain();

      // FIFO full: m0 reads pile up with responses held; m1 writes keep flowing.
      gen_en = 1'b1; hold_resp = 1'b1; req_pct = 100; rd_pct = '{100, 0};
      lat_lo = 1; lat_hi = 3;
      run(30);
      hold_resp = 1'b0;
      run(30);
      drain();

      // Spurious response with nothing pending.
      spur_now = 1'b1; run(1); spur_now = 1'b0;
      run(3);

      // Reset with reads pending discards them and clears the error flag.
      gen_en = 1'b1; hold_resp = 1'b1; req_pct = 100; rd_pct = '{100, 100};
      run(6);
      gen_en = 1'b0;
      rst = 1'b1; run(1); rst = 1'b0; hold_resp = 1'b0;
      run(3);

      // Long mixed run with stalls and occasional response hold-off.
      gen_en = 1'b1; req_pct = 70; rd_pct = '{60, 40}; stall_pct = 25; lat_lo = 1; lat_hi = 6;
      for (int i = 0; i < 20; i++) begin
         hold_resp = ($urandom_range(3) == 0);
         run(30);
      end
      hold_resp = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
